// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-register fields seen by the hazard controller and the stall/flush/forward
// controls it returns. The pipeline side drives the master modport and the controller uses the slave modport.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       rs1_d_i, rs2_d_i;
  logic [4:0]       rs1_x_i, rs2_x_i, rd_x_i;
  logic             memread_x_i, regwrite_x_i;
  logic [4:0]       rd_m_i;
  logic             regwrite_m_i, memread_m_i, memwrite_m_i;
  logic [4:0]       rd_w_i;
  logic             regwrite_w_i;
  logic             branchtaken_i;
  logic             dmem_ready_i;
  logic             stall_pc_o, stall_fd_o, stall_dx_o, stall_xm_o;
  logic             flush_fd_o, flush_dx_o, flush_xm_o, flush_mw_o;
  logic [1:0]       fwd_a_o, fwd_b_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;
  logic             error_o;
  logic [1:0]       dbg_state_o;

  modport master (
    output rs1_d_i, rs2_d_i, rs1_x_i, rs2_x_i, rd_x_i, memread_x_i, regwrite_x_i,
           rd_m_i, regwrite_m_i, memread_m_i, memwrite_m_i, rd_w_i, regwrite_w_i,
           branchtaken_i, dmem_ready_i,
    input  stall_pc_o, stall_fd_o, stall_dx_o, stall_xm_o,
           flush_fd_o, flush_dx_o, flush_xm_o, flush_mw_o,
           fwd_a_o, fwd_b_o, stall_cnt_o, flush_cnt_o, error_o, dbg_state_o
  );

  modport slave (
    input  rs1_d_i, rs2_d_i, rs1_x_i, rs2_x_i, rd_x_i, memread_x_i, regwrite_x_i,
           rd_m_i, regwrite_m_i, memread_m_i, memwrite_m_i, rd_w_i, regwrite_w_i,
           branchtaken_i, dmem_ready_i,
    output stall_pc_o, stall_fd_o, stall_dx_o, stall_xm_o,
           flush_fd_o, flush_dx_o, flush_xm_o, flush_mw_o,
           fwd_a_o, fwd_b_o, stall_cnt_o, flush_cnt_o, error_o, dbg_state_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: data-memory wait/timeout FSM, branch flush,
// load-use stall, operand forwarding and saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input logic              clk_i,
  input logic              reset_i,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;
  // The wait counter reaches MEM_TIMEOUT-1 on the increment made from this value.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 2);

  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, ERR = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic              mem_busy, load_use, hold_all;
  logic              stall_pc, stall_fd, stall_dx, stall_xm;
  logic              flush_fd, flush_dx, flush_xm, flush_mw;
  logic              unused_regwrite_x;

  assign unused_regwrite_x = bus.regwrite_x_i;

  assign mem_busy = (bus.memread_m_i | bus.memwrite_m_i) & ~bus.dmem_ready_i;
  assign load_use = bus.memread_x_i & (bus.rd_x_i != 5'd0) &
                    ((bus.rd_x_i == bus.rs1_d_i) | (bus.rd_x_i == bus.rs2_d_i));
  assign hold_all = mem_busy | (state_q == ERR);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      RUN: begin
        if (mem_busy) begin
          state_d = MEM_WAIT;
          wait_d  = '0;
        end
      end
      MEM_WAIT: begin
        if (!mem_busy)              state_d = RUN;
        else if (wait_q == WAIT_LAST) state_d = ERR;
        else                        wait_d  = wait_q + WAIT_W'(1);
      end
      ERR:     state_d = ERR;
      default: state_d = RUN;
    endcase
  end

  // Priority: memory wait / error > taken branch > load-use. Reset flushes everything.
  always_comb begin
    stall_pc = 1'b0;
    stall_fd = 1'b0;
    stall_dx = 1'b0;
    stall_xm = 1'b0;
    flush_fd = 1'b0;
    flush_dx = 1'b0;
    flush_xm = 1'b0;
    flush_mw = 1'b0;
    if (reset_i) begin
      flush_fd = 1'b1;
      flush_dx = 1'b1;
      flush_xm = 1'b1;
      flush_mw = 1'b1;
    end else if (hold_all) begin
      stall_pc = 1'b1;
      stall_fd = 1'b1;
      stall_dx = 1'b1;
      stall_xm = 1'b1;
      flush_mw = 1'b1;
    end else if (bus.branchtaken_i) begin
      flush_fd = 1'b1;
      flush_dx = 1'b1;
      flush_xm = 1'b1;
    end else if (load_use) begin
      stall_pc = 1'b1;
      stall_fd = 1'b1;
      flush_dx = 1'b1;
    end
  end

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (bus.regwrite_m_i && bus.rd_m_i != 5'd0 && bus.rd_m_i == rs)      return 2'b10;
    else if (bus.regwrite_w_i && bus.rd_w_i != 5'd0 && bus.rd_w_i == rs) return 2'b01;
    else                                                                 return 2'b00;
  endfunction

  assign stall_cnt_d = (stall_pc && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  assign flush_cnt_d = (flush_xm && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= RUN;
      wait_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_pc_o  = stall_pc;
  assign bus.stall_fd_o  = stall_fd;
  assign bus.stall_dx_o  = stall_dx;
  assign bus.stall_xm_o  = stall_xm;
  assign bus.flush_fd_o  = flush_fd;
  assign bus.flush_dx_o  = flush_dx;
  assign bus.flush_xm_o  = flush_xm;
  assign bus.flush_mw_o  = flush_mw;
  assign bus.fwd_a_o     = reset_i ? 2'b00 : fwd_sel(bus.rs1_x_i);
  assign bus.fwd_b_o     = reset_i ? 2'b00 : fwd_sel(bus.rs2_x_i);
  assign bus.stall_cnt_o = stall_cnt_q;
  assign bus.flush_cnt_o = flush_cnt_q;
  assign bus.error_o     = (state_q == ERR);
  assign bus.dbg_state_o = state_q;
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, the maximum number of data-memory wait cycles before the error state.
REQ-002 SHALL have parameter CNT_W, default 32, the width of the performance counters.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_i  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports rs1_d_i, rs2_d_i  input  5 each  source register addresses of the instruction in Decode.
REQ-006 SHALL have ports rs1_x_i, rs2_x_i, rd_x_i  input  5 each  register addresses held in the DX register.
REQ-007 SHALL have ports memread_x_i, regwrite_x_i  input  1 each  DX-register controls.
REQ-008 SHALL have ports rd_m_i (5), regwrite_m_i (1), memread_m_i (1), memwrite_m_i (1)  input  XM-register fields.
REQ-009 SHALL have ports rd_w_i (5), regwrite_w_i (1)  input  MW-register fields.
REQ-010 SHALL have port branchtaken_i  input  1  branch resolved taken in Memory stage.
REQ-011 SHALL have port dmem_ready_i  input  1  data memory can complete this cycle's access.
REQ-012 SHALL have ports stall_pc_o, stall_fd_o, stall_dx_o, stall_xm_o  output  1 each  hold the corresponding register.
REQ-013 SHALL have ports flush_fd_o, flush_dx_o, flush_xm_o, flush_mw_o  output  1 each  load a bubble into the corresponding register.
REQ-014 SHALL have ports fwd_a_o, fwd_b_o  output  2 each  ALU operand select: 00 register file, 01 MW result, 10 XM result.
REQ-015 SHALL have ports stall_cnt_o, flush_cnt_o  output  CNT_W each  performance counters.
REQ-016 SHALL have port error_o  output  1  sticky memory-timeout flag.

Function
REQ-017 SHALL implement FSM states RUN, MEM_WAIT, ERR.
REQ-018 SHALL define mem_busy = (memread_m_i | memwrite_m_i) & ~dmem_ready_i.
REQ-019 SHALL transition RUN->MEM_WAIT when mem_busy, MEM_WAIT->RUN when dmem_ready_i, and MEM_WAIT->ERR when the wait counter reaches MEM_TIMEOUT-1 while still busy; ERR SHALL be left only by reset.
REQ-020 SHALL, whenever mem_busy (RUN or MEM_WAIT), assert all four stall outputs and flush_mw_o, and suppress every other flush in that cycle.
REQ-021 SHALL clear the wait counter on entry to MEM_WAIT and increment it each MEM_WAIT cycle.
REQ-022 SHALL, in ERR, assert all stall outputs and flush_mw_o every cycle and hold error_o=1.
REQ-023 SHALL, with no mem_busy and branchtaken_i=1, assert flush_fd_o, flush_dx_o, and flush_xm_o in the same cycle and no stall.
REQ-024 SHALL detect load-use as memread_x_i & (rd_x_i!=0) & (rd_x_i==rs1_d_i | rd_x_i==rs2_d_i).
REQ-025 SHALL, on load-use with no mem_busy and no branch, assert stall_pc_o, stall_fd_o, and flush_dx_o for exactly that cycle.
REQ-026 SHALL apply priority mem_busy > branch > load-use.
REQ-027 SHALL select fwd_a_o=10 when regwrite_m_i & rd_m_i!=0 & rd_m_i==rs1_x_i, else 01 when regwrite_w_i & rd_w_i!=0 & rd_w_i==rs1_x_i, else 00; fwd_b_o SHALL use the same rule with rs2_x_i.
REQ-028 SHALL drive all stall, flush, and forward outputs combinationally from current inputs and state.
REQ-029 SHALL increment stall_cnt_o every cycle in which stall_pc_o=1, and flush_cnt_o every cycle in which flush_xm_o=1.
REQ-030 SHALL saturate both counters at all-ones with no wrap.

Reset
REQ-031 SHALL, while reset_i=1 (asynchronously), force state RUN, wait counter 0, both counters 0, and error_o 0.
REQ-032 SHALL, during reset, drive flush_fd_o, flush_dx_o, flush_xm_o, and flush_mw_o to 1, all stalls to 0, and both forward selects to 00.
REQ-033 SHALL, on reset asserted mid-MEM_WAIT or in ERR, return to RUN with error_o cleared and no residual stall after deassertion.

Verification
REQ-034 SHALL be checked by: rd_m=5, regwrite_m=1, rs1_x=5, rd_w=5, regwrite_w=1 -> fwd_a_o=10; same with rd_m=0 -> fwd_a_o=01.
REQ-035 SHALL be checked by: memread_x=1, rd_x=7, rs2_d=7 for one cycle -> stall_pc_o=stall_fd_o=flush_dx_o=1 for one cycle, stall_cnt_o=1.
REQ-036 SHALL be checked by: branchtaken_i=1 together with a load-use hazard -> flush_fd/dx/xm=1, stall_pc_o=0, flush_cnt_o=1.
REQ-037 SHALL be checked by: memread_m=1, dmem_ready low for 3 cycles and then high -> four stalls plus flush_mw_o for 3 cycles, then RUN, stall_cnt_o=3.
REQ-038 SHALL be checked by: dmem_ready held low with MEM_TIMEOUT=16 -> ERR entered after 16 busy cycles, error_o=1 persists, and reset clears it.
REQ-039 SHALL be checked by: CNT_W=4 and 20 stall cycles -> stall_cnt_o=15.
